// File: rtl/tb_sim_ctrl.sv
// Simulation controller: core reset sequencing, cycle watchdog and
// aggregation of per-channel pass/fail/exit reports into one verdict.
module tb_sim_ctrl #(
   parameter int NUM_CH            = 1,
   parameter int RESET_WAIT_CYCLES = 4,
   parameter int CNT_WIDTH         = 32,
   parameter bit WAIT_ALL          = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [CNT_WIDTH-1:0]         maxcycles_i,
   input  logic [NUM_CH-1:0]            tests_passed_i,
   input  logic [NUM_CH-1:0]            tests_failed_i,
   input  logic [NUM_CH-1:0]            exit_valid_i,
   input  logic [NUM_CH*32-1:0]         exit_value_i,
   output logic                         core_rst_no,
   output logic                         fetch_enable_o,
   output logic                         done_o,
   output logic [1:0]                   status_o,
   output logic [31:0]                  exit_code_o,
   output logic [$clog2(NUM_CH):0]      fail_chan_o,
   output logic [CNT_WIDTH-1:0]         cycle_cnt_o
);

   localparam int FW = $clog2(NUM_CH) + 1;
   localparam int HW = $clog2(RESET_WAIT_CYCLES + 2);

   localparam logic [1:0] ST_PASS = 2'b01;
   localparam logic [1:0] ST_FAIL = 2'b10;
   localparam logic [1:0] ST_TOUT = 2'b11;

   typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

   state_t              state;
   logic [HW-1:0]       hold_cnt;
   logic [NUM_CH-1:0]   chan_done;

   logic [NUM_CH-1:0]   fail_v;
   logic [NUM_CH-1:0]   ok_v;
   logic [FW-1:0]       fail_idx;
   logic [31:0]         fail_code;
   logic                any_fail;
   logic                pass_hit;
   logic                tout_hit;
   logic                hold_go;
   logic [HW-1:0]       hold_nxt;
   logic [CNT_WIDTH-1:0] cnt_nxt;

   // Channels already resolved contribute no further events.
   always_comb begin
      fail_v = '0;
      ok_v   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         fail_v[k] = !chan_done[k] &
                     (tests_failed_i[k] |
                      (exit_valid_i[k] & (exit_value_i[32*k +: 32] != 32'h0)));
         ok_v[k]   = !chan_done[k] & !fail_v[k] &
                     (tests_passed_i[k] |
                      (exit_valid_i[k] & (exit_value_i[32*k +: 32] == 32'h0)));
      end
   end

   // Descending scan leaves the lowest failing channel selected.
   always_comb begin
      fail_idx  = '0;
      fail_code = 32'h1;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (fail_v[k]) begin
            fail_idx  = FW'(k);
            fail_code = exit_valid_i[k] ? exit_value_i[32*k +: 32] : 32'h1;
         end
      end
   end

   assign any_fail = |fail_v;
   assign pass_hit = WAIT_ALL ? (&(chan_done | ok_v)) : (|ok_v);
   assign tout_hit = (maxcycles_i != '0) &&
                     (cycle_cnt_o >= (maxcycles_i - CNT_WIDTH'(1)));
   assign hold_nxt = hold_cnt + HW'(1);
   assign hold_go  = hold_nxt >= HW'(RESET_WAIT_CYCLES);
   assign cnt_nxt  = (&cycle_cnt_o) ? cycle_cnt_o
                                    : cycle_cnt_o + CNT_WIDTH'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= HOLD;
         hold_cnt       <= '0;
         chan_done      <= '0;
         core_rst_no    <= 1'b0;
         fetch_enable_o <= 1'b0;
         done_o         <= 1'b0;
         status_o       <= 2'b00;
         exit_code_o    <= 32'h0;
         fail_chan_o    <= '0;
         cycle_cnt_o    <= '0;
      end else begin
         case (state)
            HOLD: begin
               hold_cnt <= hold_nxt;
               if (hold_go) begin
                  state          <= RUN;
                  core_rst_no    <= 1'b1;
                  fetch_enable_o <= 1'b1;
               end
            end
            RUN: begin
               cycle_cnt_o <= cnt_nxt;
               chan_done   <= chan_done | ok_v | fail_v;
               if (any_fail) begin
                  state          <= DONE;
                  done_o         <= 1'b1;
                  fetch_enable_o <= 1'b0;
                  status_o       <= ST_FAIL;
                  fail_chan_o    <= fail_idx;
                  exit_code_o    <= fail_code;
               end else if (pass_hit) begin
                  state          <= DONE;
                  done_o         <= 1'b1;
                  fetch_enable_o <= 1'b0;
                  status_o       <= ST_PASS;
                  exit_code_o    <= 32'h0;
               end else if (tout_hit) begin
                  state          <= DONE;
                  done_o         <= 1'b1;
                  fetch_enable_o <= 1'b0;
                  status_o       <= ST_TOUT;
                  exit_code_o    <= 32'hFFFF_FFFF;
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: state <= HOLD;
         endcase
      end
   end

endmodule
